// File: rtl/noc_flit_router.sv
// noc_flit_router: flit FIFO + wormhole forwarding of NI packets to one of four output ports
module noc_flit_router #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [5:0] HEADER_TAG = 6'b101111,
  parameter logic [7:0] TAIL_FLIT  = 8'hFF,
  parameter int         MAX_DATA   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_flit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_flit,
  output logic [3:0] out_valid,
  input  logic [3:0] out_ready,
  output logic       bad_header,
  output logic [7:0] pkt_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_DATA + 1);
  typedef enum logic {IDLE, FWD} state_t;
  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    dest_q, dest_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [7:0]    slot_flit_q, slot_flit_d;
  logic [3:0]    slot_valid_q, slot_valid_d;
  logic          slot_last_q, slot_last_d;
  logic          bad_q, bad_d;
  logic [7:0]    pkt_q, pkt_d;
  logic [7:0]    head;
  logic          empty, is_hdr, closing, slot_take, slot_free, push, pop, load, discard;
  assign head      = mem_q[rd_ptr_q];
  assign empty     = count_q == '0;
  assign in_ready  = count_q != (AW+1)'(FIFO_DEPTH);
  assign is_hdr    = head[7:2] == HEADER_TAG;
  assign closing   = head == TAIL_FLIT || dcnt_q == CW'(MAX_DATA);
  assign slot_take = |(slot_valid_q & out_ready);
  assign slot_free = slot_valid_q == '0 || slot_take;
  assign push      = in_valid && in_ready;
  assign out_flit   = slot_flit_q;
  assign out_valid  = slot_valid_q;
  assign bad_header = bad_q;
  assign pkt_count  = pkt_q;
  // FSM state register
  always_ff @(posedge clk)
    state_q <= !rst_n ? IDLE : state_d;
  // FSM next state: enter FWD when a header reaches the slot, leave when the closing flit does
  always_comb
    state_d = (!empty && state_q == IDLE && is_hdr && slot_free) ? FWD :
              (!empty && state_q == FWD && slot_free && closing) ? IDLE : state_q;
  // FSM outputs: slot load, discard of stray flits, FIFO pointers and counters
  always_comb begin
    load         = !empty && slot_free && (state_q == FWD || is_hdr);
    discard      = !empty && state_q == IDLE && !is_hdr;
    pop          = load || discard;
    wr_ptr_d     = wr_ptr_q + AW'(push);
    rd_ptr_d     = rd_ptr_q + AW'(pop);
    count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
    dest_d       = (load && state_q == IDLE) ? head[1:0] : dest_q;
    dcnt_d       = (load && state_q == IDLE) ? '0 : (load ? dcnt_q + 1'b1 : dcnt_q);
    slot_flit_d  = load ? head : slot_flit_q;
    slot_valid_d = load ? 4'b0001 << (state_q == IDLE ? head[1:0] : dest_q) :
                   (slot_take ? 4'b0000 : slot_valid_q);
    slot_last_d  = load ? (state_q == FWD && closing) : slot_last_q;
    bad_d        = discard;
    pkt_d        = pkt_q + 8'(slot_take && slot_last_q);
  end
  // datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dest_q       <= '0;
      dcnt_q       <= '0;
      slot_flit_q  <= '0;
      slot_valid_q <= '0;
      slot_last_q  <= 1'b0;
      bad_q        <= 1'b0;
      pkt_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dest_q       <= dest_d;
      dcnt_q       <= dcnt_d;
      slot_flit_q  <= slot_flit_d;
      slot_valid_q <= slot_valid_d;
      slot_last_q  <= slot_last_d;
      bad_q        <= bad_d;
      pkt_q        <= pkt_d;
    end
  end
  // FIFO storage, contents need no reset
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= in_flit;
endmodule

// File: tb/tb_noc_flit_router.sv
// tb_noc_flit_router: vector table, corner-case sequences and randomized packet-level model check
module tb_noc_flit_router;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_flit = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_flit;
  logic [3:0] out_valid;
  logic [3:0] out_ready = 4'h0;
  logic       bad_header;
  logic [7:0] pkt_count;

  noc_flit_router dut (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .bad_header(bad_header), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0] fl;
    logic       v;
    logic [3:0] rdy;
    logic       e_ir;
    logic [3:0] e_ov;
    logic [7:0] e_of;
    logic       e_bad;
    logic [7:0] e_pkt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [7:0] fl, input logic v, input logic [3:0] rdy, input logic ir,
                     input logic [3:0] ov, input logic [7:0] of, input logic bad, input logic [7:0] pkt);
    vec_t r;
    r.fl = fl; r.v = v; r.rdy = rdy; r.e_ir = ir; r.e_ov = ov; r.e_of = of; r.e_bad = bad; r.e_pkt = pkt;
    tbl.push_back(r);
  endtask

  logic [9:0] got[$];
  logic [9:0] exp_q[$];
  logic [7:0] stim[$];
  int         bad_seen = 0;
  int         exp_bad, exp_pkt;
  logic       prev_stall = 1'b0;
  logic [3:0] prev_ov;
  logic [7:0] prev_of;

  // monitor: handshakes, bad pulses and hold-while-stalled, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 4; d++)
        if (out_valid[d] && out_ready[d]) got.push_back({2'(d), out_flit});
      if (bad_header) bad_seen++;
      if (prev_stall) begin
        chk("hold_valid", {28'd0, out_valid}, {28'd0, prev_ov});
        chk("hold_flit", {24'd0, out_flit}, {24'd0, prev_of});
      end
      if ($countones(out_valid) > 1) chk("onehot", {28'd0, out_valid}, 32'd0);
      prev_stall = |(out_valid & ~out_ready);
      prev_ov = out_valid;
      prev_of = out_flit;
    end else prev_stall = 1'b0;
  end

  // packet-level reference: walk the accepted flit stream through the routing rules
  task automatic model();
    bit in_pkt = 0;
    logic [1:0] dst = 2'd0;
    int n = 0;
    exp_q.delete();
    exp_bad = 0;
    exp_pkt = 0;
    foreach (stim[i]) begin
      if (!in_pkt) begin
        if (stim[i][7:2] == 6'b101111) begin
          in_pkt = 1; dst = stim[i][1:0]; n = 0;
          exp_q.push_back({dst, stim[i]});
        end else exp_bad++;
      end else begin
        exp_q.push_back({dst, stim[i]});
        if (stim[i] == 8'hFF || n == 4) begin in_pkt = 0; exp_pkt++; end
        else n++;
      end
    end
  endtask

  task automatic push_flit(input logic [7:0] f);
    logic acc;
    int n = 0;
    in_flit = f;
    in_valid = 1'b1;
    do begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 30);
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic cmp_got(input string name);
    chk({name, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_flit%0d", name, i), {22'd0, got[i]}, {22'd0, exp_q[i]});
  endtask

  initial begin #2000000; $display("FAIL watchdog: simulation did not end"); $fatal(1); end

  initial begin
    logic [7:0] seq[$];
    int idx, cyc;
    logic acc;
    // reset with in_valid held high
    in_valid = 1'b1; in_flit = 8'hBE;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_out_flit", {24'd0, out_flit}, 32'd0);
    chk("rst_pkt", {24'd0, pkt_count}, 32'd0);
    chk("rst_bad", {31'd0, bad_header}, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_no_push", {28'd0, out_valid}, 32'd0);
    // cycle table: full packet, bad headers, back-to-back short packets, bad then good
    add(8'hBE,1,4'hF, 1,4'h0,8'h00,0,8'd0);
    add(8'h11,1,4'hF, 1,4'h4,8'hBE,0,8'd0);
    add(8'h22,1,4'hF, 1,4'h4,8'h11,0,8'd0);
    add(8'h33,1,4'hF, 1,4'h4,8'h22,0,8'd0);
    add(8'h44,1,4'hF, 1,4'h4,8'h33,0,8'd0);
    add(8'hFF,1,4'hF, 1,4'h4,8'h44,0,8'd0);
    add(8'h00,0,4'hF, 1,4'h4,8'hFF,0,8'd0);
    add(8'h00,0,4'hF, 1,4'h0,8'h00,0,8'd1);
    add(8'h12,1,4'hF, 1,4'h0,8'h00,0,8'd1);
    add(8'hFF,1,4'hF, 1,4'h0,8'h00,1,8'd1);
    add(8'h00,0,4'hF, 1,4'h0,8'h00,1,8'd1);
    add(8'h00,0,4'hF, 1,4'h0,8'h00,0,8'd1);
    add(8'hBD,1,4'hF, 1,4'h0,8'h00,0,8'd1);
    add(8'h55,1,4'hF, 1,4'h2,8'hBD,0,8'd1);
    add(8'hFF,1,4'hF, 1,4'h2,8'h55,0,8'd1);
    add(8'hBC,1,4'hF, 1,4'h2,8'hFF,0,8'd1);
    add(8'h01,1,4'hF, 1,4'h1,8'hBC,0,8'd2);
    add(8'hFF,1,4'hF, 1,4'h1,8'h01,0,8'd2);
    add(8'h00,0,4'hF, 1,4'h1,8'hFF,0,8'd2);
    add(8'h00,0,4'hF, 1,4'h0,8'h00,0,8'd3);
    add(8'h12,1,4'hF, 1,4'h0,8'h00,0,8'd3);
    add(8'hBE,1,4'hF, 1,4'h0,8'h00,1,8'd3);
    add(8'h07,1,4'hF, 1,4'h4,8'hBE,0,8'd3);
    add(8'hFF,1,4'hF, 1,4'h4,8'h07,0,8'd3);
    add(8'h00,0,4'hF, 1,4'h4,8'hFF,0,8'd3);
    add(8'h00,0,4'hF, 1,4'h0,8'h00,0,8'd4);
    foreach (tbl[i]) begin
      in_flit = tbl[i].fl; in_valid = tbl[i].v; out_ready = tbl[i].rdy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d ir/ov/of/bad/pkt", i),
          {10'd0, in_ready, out_valid, (tbl[i].e_ov != 4'h0 ? out_flit : tbl[i].e_of), bad_header, pkt_count},
          {10'd0, tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_of, tbl[i].e_bad, tbl[i].e_pkt});
    end
    in_valid = 1'b0;
    // backpressure on port 3 while the other ready bits are high
    got.delete();
    out_ready = 4'b0111;
    seq = '{8'hBF, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    foreach (seq[i]) push_flit(seq[i]);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_out_flit", {24'd0, out_flit}, 32'hBF);
    chk("bp_out_valid", {28'd0, out_valid}, 32'h8);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_still_held", {19'd0, in_ready, out_valid, out_flit}, {19'd0, 1'b0, 4'h8, 8'hBF});
    out_ready = 4'hF;
    push_flit(8'hFF);
    repeat (10) @(posedge clk);
    #1;
    exp_q.delete();
    foreach (seq[i]) exp_q.push_back({2'd3, seq[i]});
    exp_q.push_back({2'd3, 8'hFF});
    cmp_got("bp");
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("bp_pkt", {24'd0, pkt_count}, 32'd5);
    // over-length packet closed by its fifth data flit, next flit is a new header
    got.delete();
    seq = '{8'hBC, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hBD, 8'hFF};
    foreach (seq[i]) push_flit(seq[i]);
    repeat (10) @(posedge clk);
    #1;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back({2'd0, seq[i]});
    exp_q.push_back({2'd1, 8'hBD});
    exp_q.push_back({2'd1, 8'hFF});
    cmp_got("ovl");
    chk("ovl_pkt", {24'd0, pkt_count}, 32'd7);
    // randomized traffic with random downstream readiness
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    got.delete();
    bad_seen = 0;
    stim.delete();
    while (stim.size() < 300) begin
      if ($urandom_range(0, 9) == 0) stim.push_back(8'($urandom));
      else begin
        stim.push_back({6'b101111, 2'($urandom)});
        for (int k = $urandom_range(0, 5); k > 0; k--)
          stim.push_back($urandom_range(0, 7) == 0 ? 8'hFF : 8'($urandom_range(0, 254)));
        if ($urandom_range(0, 4) != 0) stim.push_back(8'hFF);
      end
    end
    idx = 0;
    cyc = 0;
    while (idx < stim.size() && cyc < 6000) begin
      out_ready = 4'($urandom);
      in_valid = $urandom_range(0, 3) != 0;
      in_flit = stim[idx];
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 4'hF;
    repeat (20) @(posedge clk);
    #1;
    chk("rand_all_sent", idx, stim.size());
    model();
    cmp_got("rand");
    chk("rand_bad", bad_seen, exp_bad);
    chk("rand_pkt", {24'd0, pkt_count}, {24'd0, 8'(exp_pkt)});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
